// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display blocks.
package display_pkg;

  typedef enum logic [1:0] {
    PAGE_AB   = 2'd0,
    PAGE_SUM  = 2'd1,
    PAGE_DIFF = 2'd2
  } page_t;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] ANODE_IDLE = 4'b1111;

  // Active-low anode for a digit index; idx 0 is the rightmost digit.
  function automatic logic [3:0] anode_of(input digit_idx_t idx);
    return ANODE_IDLE ^ (4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_page_sequencer_scan_prescaler.sv
// Free-running scan prescaler: one-cycle tick every 2^SCAN_BITS clocks.
module scan_prescaler #(
  parameter int SCAN_BITS = 17
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [SCAN_BITS-1:0] count_r;

  // Wrapping clock counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + SCAN_BITS'(1);
    end
  end

  assign tick = &count_r;

endmodule

// File: rtl/display_page_sequencer.sv
// Scans the four-digit display and steps between the AB, SUM and DIFF pages
// on a button edge or after an auto-dwell period, always at frame boundaries.
module display_page_sequencer
  import display_pkg::*;
#(
  parameter int SCAN_BITS    = 17,
  parameter int DWELL_FRAMES = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       advance,
  input  logic       auto_en,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       blank,
  output logic [1:0] page
);

  localparam int DW = $clog2(DWELL_FRAMES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  logic          tick_s;
  digit_idx_t    idx_r;
  digit_idx_t    idx_next_s;
  page_t         page_r;
  page_t         page_next_s;
  logic [3:0]    a_snap_r;
  logic [3:0]    b_snap_r;
  logic          pending_r;
  logic          adv_prev_r;
  logic [DW-1:0] dwell_r;
  logic          frame_end_s;
  logic          adv_rise_s;
  logic          dwell_done_s;
  logic          page_illegal_s;
  logic          page_step_s;
  logic [3:0]    a_view_s;
  logic [3:0]    b_view_s;
  logic [4:0]    sum_s;
  logic [3:0]    diff_s;
  logic          borrow_s;
  logic          blank_next_s;
  logic [3:0]    digit_next_s;

  scan_prescaler #(.SCAN_BITS(SCAN_BITS)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  assign idx_next_s     = idx_r + 2'd1;
  assign frame_end_s    = tick_s && (idx_r == 2'd3);
  assign adv_rise_s     = advance && !adv_prev_r;
  assign dwell_done_s   = auto_en && (dwell_r == DWELL_LAST);
  assign page_illegal_s = (page_r != PAGE_AB) && (page_r != PAGE_SUM) && (page_r != PAGE_DIFF);
  assign page_step_s    = frame_end_s && (pending_r || dwell_done_s || page_illegal_s);

  // The frame-start digit must already show the freshly snapshotted operands.
  assign a_view_s = frame_end_s ? A : a_snap_r;
  assign b_view_s = frame_end_s ? B : b_snap_r;
  assign sum_s    = {1'b0, a_view_s} + {1'b0, b_view_s};
  assign diff_s   = a_view_s - b_view_s;
  assign borrow_s = a_view_s < b_view_s;

  // Page state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      page_r <= PAGE_AB;
    end else begin
      page_r <= page_next_s;
    end
  end

  // Page next-state: rotate on a qualified frame boundary; illegal code recovers to AB.
  always_comb begin
    page_next_s = page_r;
    if (page_step_s) begin
      case (page_r)
        PAGE_AB:   page_next_s = PAGE_SUM;
        PAGE_SUM:  page_next_s = PAGE_DIFF;
        PAGE_DIFF: page_next_s = PAGE_AB;
        default:   page_next_s = PAGE_AB;
      endcase
    end else begin
      page_next_s = page_r;
    end
  end

  // Content mux for the digit about to be selected.
  always_comb begin
    blank_next_s = 1'b1;
    digit_next_s = 4'd0;
    case (page_next_s)
      PAGE_AB: begin
        case (idx_next_s)
          2'd0:    begin blank_next_s = 1'b0; digit_next_s = b_view_s; end
          2'd3:    begin blank_next_s = 1'b0; digit_next_s = a_view_s; end
          default: begin blank_next_s = 1'b1; digit_next_s = 4'd0;     end
        endcase
      end
      PAGE_SUM: begin
        case (idx_next_s)
          2'd0:    begin blank_next_s = 1'b0; digit_next_s = sum_s[3:0];        end
          2'd1:    begin blank_next_s = 1'b0; digit_next_s = {3'b000, sum_s[4]}; end
          default: begin blank_next_s = 1'b1; digit_next_s = 4'd0;              end
        endcase
      end
      PAGE_DIFF: begin
        case (idx_next_s)
          2'd0:    begin blank_next_s = 1'b0; digit_next_s = diff_s;              end
          2'd1:    begin blank_next_s = 1'b0; digit_next_s = {3'b000, borrow_s};  end
          default: begin blank_next_s = 1'b1; digit_next_s = 4'd0;                end
        endcase
      end
      default: begin
        blank_next_s = 1'b1;
        digit_next_s = 4'd0;
      end
    endcase
  end

  // Scan position and registered display outputs, updated on each tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_r <= 2'd0;
      an    <= 4'b1110;
      digit <= 4'd0;
      blank <= 1'b0;
    end else if (tick_s) begin
      idx_r <= idx_next_s;
      an    <= anode_of(idx_next_s);
      digit <= digit_next_s;
      blank <= blank_next_s;
    end else begin
      idx_r <= idx_r;
      an    <= an;
      digit <= digit;
      blank <= blank;
    end
  end

  // Operand snapshot at frame start, button edge detect, pending request and dwell timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_snap_r   <= 4'd0;
      b_snap_r   <= 4'd0;
      adv_prev_r <= 1'b0;
      pending_r  <= 1'b0;
      dwell_r    <= '0;
    end else begin
      adv_prev_r <= advance;
      if (frame_end_s) begin
        a_snap_r <= A;
        b_snap_r <= B;
      end else begin
        a_snap_r <= a_snap_r;
        b_snap_r <= b_snap_r;
      end
      if (page_step_s) begin
        pending_r <= 1'b0;
      end else if (adv_rise_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (!auto_en || adv_rise_s || page_step_s) begin
        dwell_r <= '0;
      end else if (frame_end_s) begin
        dwell_r <= dwell_r + DW'(1);
      end else begin
        dwell_r <= dwell_r;
      end
    end
  end

  assign page = page_r;

endmodule

// File: tb/tb_display_page_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed per-tick display states,
// a monitor pops and compares each time the anode walk moves.
module tb_display_page_sequencer;

  typedef struct packed {
    logic [3:0] an;
    logic [1:0] page;
    logic       blank;
    logic [3:0] digit;
  } obs_t;

  localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [4:0] BL = 5'h10;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] A       = 4'd3;
  logic [3:0] B       = 4'd9;
  logic       advance = 1'b0;
  logic       auto_en = 1'b0;
  logic [3:0] an;
  logic [3:0] digit;
  logic       blank;
  logic [1:0] page;

  int   tests = 0;
  int   fails = 0;
  obs_t exp_q[$];
  logic [3:0] mon_last_an = 4'b1110;

  display_page_sequencer #(.SCAN_BITS(2), .DWELL_FRAMES(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .advance (advance),
    .auto_en (auto_en),
    .an      (an),
    .digit   (digit),
    .blank   (blank),
    .page    (page)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got an=%b page=%0d blank=%b digit=%h, required an=%b page=%0d blank=%b digit=%h",
               name, got.an, got.page, got.blank, got.digit, want.an, want.page, want.blank, want.digit);
    end
  endfunction

  task automatic push_entry(input int idx, input logic [1:0] pg, input logic [4:0] e);
    obs_t o;
    o.an    = AN_TAB[idx];
    o.page  = pg;
    o.blank = e[4];
    o.digit = e[3:0];
    exp_q.push_back(o);
  endtask

  // One full frame of expectations (digits listed idx3..idx0) plus stimulus mode:
  // 1 = pulse before the boundary, 2 = three mid-frame pulses,
  // 3 = edge on the frame-ending tick, 4 = change A mid-frame.
  task automatic frame(input logic [1:0] pg, input logic [4:0] e3, input logic [4:0] e2,
                       input logic [4:0] e1, input logic [4:0] e0, input int mode);
    logic [4:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) push_entry(i, pg, e[i]);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        1:       advance = (k == 0);
        2:       advance = (k == 4) || (k == 6) || (k == 8);
        3:       advance = (k == 3);
        4:       if (k == 8) A = 4'hC;
        default: advance = 1'b0;
      endcase
      @(negedge clock);
    end
    advance = 1'b0;
  endtask

  // Monitor: every anode change is one display update to compare.
  initial begin
    forever begin
      @(negedge clock);
      if (an !== mon_last_an) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_update: an=%b page=%0d blank=%b digit=%h, required no update",
                   an, page, blank, digit);
        end else begin
          check("scan", {an, page, blank, digit}, exp_q.pop_front());
        end
        mon_last_an = an;
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clock);
    check("reset_state", {an, page, blank, digit}, {4'b1110, 2'd0, 1'b0, 4'd0});
    reset = 1'b0;

    // Remainder of the first frame shows the reset snapshot (A=B=0).
    push_entry(1, 2'd0, BL);
    push_entry(2, 2'd0, BL);
    push_entry(3, 2'd0, 5'h00);
    repeat (12) @(negedge clock);

    // Scenario 1: A=3, B=9 on page AB.
    frame(2'd0, 5'h03, BL, BL, 5'h09, 0);
    frame(2'd0, 5'h03, BL, BL, 5'h09, 0);

    // Scenario 2: A=9, B=8, manual steps through all pages.
    A = 4'd9; B = 4'd8;
    frame(2'd1, BL, BL, 5'h01, 5'h01, 1);
    frame(2'd2, BL, BL, 5'h00, 5'h01, 1);
    frame(2'd0, 5'h09, BL, BL, 5'h08, 1);

    // Scenario 3: A=2, B=5, difference with borrow.
    A = 4'd2; B = 4'd5;
    frame(2'd1, BL, BL, 5'h00, 5'h07, 1);
    frame(2'd2, BL, BL, 5'h01, 5'h0D, 1);

    // Scenario 4: burst of edges gives one step; edge on the ending tick lands a frame later.
    frame(2'd2, BL, BL, 5'h01, 5'h0D, 2);
    frame(2'd0, 5'h02, BL, BL, 5'h05, 0);
    frame(2'd0, 5'h02, BL, BL, 5'h05, 3);
    frame(2'd1, BL, BL, 5'h00, 5'h07, 0);

    // Scenario 5: auto dwell of two frames, then a mid-dwell button edge.
    auto_en = 1'b1;
    frame(2'd1, BL, BL, 5'h00, 5'h07, 0);
    frame(2'd2, BL, BL, 5'h01, 5'h0D, 0);
    frame(2'd2, BL, BL, 5'h01, 5'h0D, 0);
    frame(2'd0, 5'h02, BL, BL, 5'h05, 0);
    frame(2'd0, 5'h02, BL, BL, 5'h05, 0);
    frame(2'd1, BL, BL, 5'h00, 5'h07, 0);
    frame(2'd1, BL, BL, 5'h00, 5'h07, 2);
    frame(2'd2, BL, BL, 5'h01, 5'h0D, 0);
    frame(2'd2, BL, BL, 5'h01, 5'h0D, 0);
    frame(2'd0, 5'h02, BL, BL, 5'h05, 0);

    // Scenario 6: reach DIFF, reset at idx 2, then a mid-frame operand change.
    auto_en = 1'b0;
    frame(2'd1, BL, BL, 5'h00, 5'h07, 1);
    push_entry(0, 2'd2, 5'h0D);
    push_entry(1, 2'd2, 5'h01);
    push_entry(2, 2'd2, BL);
    advance = 1'b1;
    @(negedge clock);
    advance = 1'b0;
    repeat (11) @(negedge clock);
    push_entry(0, 2'd0, 5'h00);
    #2 reset = 1'b1;
    #1 check("async_reset", {an, page, blank, digit}, {4'b1110, 2'd0, 1'b0, 4'd0});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    push_entry(1, 2'd0, BL);
    push_entry(2, 2'd0, BL);
    push_entry(3, 2'd0, 5'h00);
    repeat (12) @(negedge clock);
    frame(2'd0, 5'h02, BL, BL, 5'h05, 4);
    frame(2'd0, 5'h0C, BL, BL, 5'h05, 0);

    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expected updates never seen, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
